// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, holds the icache address until data_ok,
// and queues {pc, instr} pairs for decode. Redirects flush the queue and retarget.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_n,
    output logic [31:0] instr_addr_o,
    input  logic        instr_data_ok_i,
    input  logic [31:0] instr_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_instr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic          pend;
    logic [31:0]   pend_pc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic [31:0] redir_tgt;
    logic        pop;
    logic        room;
    logic        push;

    // A redirect cycle cancels any handshake, so pop and push are both masked by it.
    assign redir_tgt = {redirect_pc_i[31:2], 2'b00};
    assign pop       = (count != '0) && out_ready_i && !redirect_valid_i;
    assign room      = (count != FULL) || pop;
    assign push      = instr_data_ok_i && !redirect_valid_i && !pend && room;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            pend    <= 1'b0;
            pend_pc <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (redirect_valid_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // The address may only move when the in-flight access completes.
            if (instr_data_ok_i) begin
                pc   <= redir_tgt;
                pend <= 1'b0;
            end else begin
                pend    <= 1'b1;
                pend_pc <= redir_tgt;
            end
        end else begin
            if (instr_data_ok_i && pend) begin
                pc   <= pend_pc;
                pend <= 1'b0;
            end else if (push) begin
                pc <= pc + 32'd4;
            end
            if (push) begin
                q_pc[wr_ptr]    <= pc;
                q_instr[wr_ptr] <= instr_data_i;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW + 1)'(1);
            end
        end
    end

    assign instr_addr_o = pc;
    assign out_valid_o  = (count != '0);
    assign out_pc_o     = q_pc[rd_ptr];
    assign out_instr_o  = q_instr[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; a mock icache returns
// {addr[15:0], 16'hC0DE} so each expected instruction is a hand-written constant.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_addr_o;
    logic        instr_data_ok_i = 1'b0;
    logic [31:0] instr_data_i = 32'hDEAD_BEEF;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_pc_o;
    logic [31:0] out_instr_o;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h8000_0000), .DEPTH(4)) dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .instr_addr_o    (instr_addr_o),
        .instr_data_ok_i (instr_data_ok_i),
        .instr_data_i    (instr_data_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_pc_o        (out_pc_o),
        .out_instr_o     (out_instr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, cross the rising edge, and land 1 time unit after it.
    task automatic applyStimulus(input logic ok, input logic [31:0] data, input logic redir,
                                 input logic [31:0] rpc, input logic rdy);
        instr_data_ok_i  = ok;
        instr_data_i     = ok ? data : 32'hDEAD_BEEF;
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        out_ready_i      = rdy;
        @(posedge clk_i);
        #1;
        instr_data_ok_i  = 1'b0;
        instr_data_i     = 32'hDEAD_BEEF;
        redirect_valid_i = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    task automatic completeAccess(input logic rdy);
        applyStimulus(1'b1, {instr_addr_o[15:0], 16'hC0DE}, 1'b0, 32'h0, rdy);
    endtask

    task automatic hit(input logic rdy);
        idle(rdy);
        idle(rdy);
        completeAccess(rdy);
    endtask

    task automatic doReset();
        rst_n            = 1'b0;
        instr_data_ok_i  = 1'b0;
        redirect_valid_i = 1'b0;
        out_ready_i      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_addr",  instr_addr_o, 32'h8000_0000);
        checkOutput("rst_valid", {31'b0, out_valid_o}, 32'h0);
        checkOutput("rst_pc",    out_pc_o, 32'h0);
        checkOutput("rst_instr", out_instr_o, 32'h0);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // In-order hits with decode always ready
        doReset();
        checkOutput("t1_valid_pre", {31'b0, out_valid_o}, 32'h0);
        hit(1'b1);
        checkOutput("t1_valid0", {31'b0, out_valid_o}, 32'h1);
        checkOutput("t1_pc0",    out_pc_o, 32'h8000_0000);
        checkOutput("t1_ins0",   out_instr_o, 32'h0000_C0DE);
        checkOutput("t1_addr1",  instr_addr_o, 32'h8000_0004);
        hit(1'b1);
        checkOutput("t1_pc1",    out_pc_o, 32'h8000_0004);
        checkOutput("t1_ins1",   out_instr_o, 32'h0004_C0DE);
        checkOutput("t1_addr2",  instr_addr_o, 32'h8000_0008);
        hit(1'b1);
        checkOutput("t1_pc2",    out_pc_o, 32'h8000_0008);
        checkOutput("t1_addr3",  instr_addr_o, 32'h8000_000C);

        // Decode stalled: queue fills to 4, later data_ok pulses are discarded
        doReset();
        repeat (6) hit(1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("t2_addr_hold", instr_addr_o, 32'h8000_0010);
        checkOutput("t2_valid",     {31'b0, out_valid_o}, 32'h1);
        checkOutput("t2_pc0",       out_pc_o, 32'h8000_0000);
        checkOutput("t2_ins0",      out_instr_o, 32'h0000_C0DE);
        idle(1'b1);
        checkOutput("t2_pc1",  out_pc_o, 32'h8000_0004);
        checkOutput("t2_ins1", out_instr_o, 32'h0004_C0DE);
        idle(1'b1);
        checkOutput("t2_pc2",  out_pc_o, 32'h8000_0008);
        idle(1'b1);
        checkOutput("t2_pc3",  out_pc_o, 32'h8000_000C);
        checkOutput("t2_ins3", out_instr_o, 32'h000C_C0DE);
        idle(1'b1);
        checkOutput("t2_empty", {31'b0, out_valid_o}, 32'h0);

        // Redirect mid-access with two entries queued
        doReset();
        hit(1'b0);
        hit(1'b0);
        idle(1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0102, 1'b0);
        checkOutput("t3_flush_valid", {31'b0, out_valid_o}, 32'h0);
        checkOutput("t3_addr_held",   instr_addr_o, 32'h8000_0008);
        completeAccess(1'b0);
        checkOutput("t3_drop_valid", {31'b0, out_valid_o}, 32'h0);
        checkOutput("t3_addr_tgt",   instr_addr_o, 32'h8000_0100);
        hit(1'b0);
        checkOutput("t3_valid", {31'b0, out_valid_o}, 32'h1);
        checkOutput("t3_pc",    out_pc_o, 32'h8000_0100);
        checkOutput("t3_ins",   out_instr_o, 32'h0100_C0DE);
        checkOutput("t3_addr",  instr_addr_o, 32'h8000_0104);

        // Redirect coincident with data_ok and pop, then two redirects before data_ok
        idle(1'b0);
        idle(1'b0);
        applyStimulus(1'b1, 32'h1234_5678, 1'b1, 32'h8000_0180, 1'b1);
        checkOutput("t4_flush_valid", {31'b0, out_valid_o}, 32'h0);
        checkOutput("t4_addr_180",    instr_addr_o, 32'h8000_0180);
        idle(1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0200, 1'b1);
        checkOutput("t4_addr_hold", instr_addr_o, 32'h8000_0180);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0301, 1'b1);
        completeAccess(1'b1);
        checkOutput("t4_drop_valid", {31'b0, out_valid_o}, 32'h0);
        checkOutput("t4_addr_300",   instr_addr_o, 32'h8000_0300);
        hit(1'b1);
        checkOutput("t4_valid", {31'b0, out_valid_o}, 32'h1);
        checkOutput("t4_pc",    out_pc_o, 32'h8000_0300);
        checkOutput("t4_ins",   out_instr_o, 32'h0300_C0DE);
        idle(1'b1);
        checkOutput("t4_only_one", {31'b0, out_valid_o}, 32'h0);

        // Address wraps from the top of the 32-bit space
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        completeAccess(1'b1);
        checkOutput("t5_addr_top", instr_addr_o, 32'hFFFF_FFFC);
        hit(1'b1);
        checkOutput("t5_pc",        out_pc_o, 32'hFFFF_FFFC);
        checkOutput("t5_ins",       out_instr_o, 32'hFFFC_C0DE);
        checkOutput("t5_addr_wrap", instr_addr_o, 32'h0000_0000);

        // Asynchronous reset mid-miss with three entries queued
        doReset();
        repeat (3) hit(1'b0);
        checkOutput("t6_addr_pre", instr_addr_o, 32'h8000_000C);
        idle(1'b0);
        idle(1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_valid", {31'b0, out_valid_o}, 32'h0);
        checkOutput("t6_addr",  instr_addr_o, 32'h8000_0000);
        checkOutput("t6_pc",    out_pc_o, 32'h0);
        checkOutput("t6_ins",   out_instr_o, 32'h0);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        hit(1'b0);
        checkOutput("t6_restart_pc",   out_pc_o, 32'h8000_0000);
        checkOutput("t6_restart_addr", instr_addr_o, 32'h8000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
